prime_screen_ctrl: RTL and testbench

Trial-division sequencer sitting between the RSA candidate source (RNG) and the shared FastDivider16_8 core. It accepts one 16-bit candidate and streams divisors 2, 3, 4, … into the divider with the candidate held as dividend. It watches the returned remainders and reports either the smallest factor found or "no small factor". The key-generation FSM uses it to reject composites before the expensive primality stage.

---
 rtl/prime_screen_ctrl.sv | 147 ++++++++++++++
 tb/tb_prime_screen_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prime_screen_ctrl.sv
// prime_screen_ctrl: trial-division sequencer in front of the shared 16/8 divider.
// Streams divisors 2..last against one held candidate and reports the smallest
// factor seen, or "no small factor".
// Optional feature macro: PRIME_SQRT_BOUND_EN (stop issuing once d*d > candidate).
module prime_screen_ctrl #(
  parameter int unsigned MAX_DIV = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cand_tvalid,
  output logic        cand_tready,
  input  logic [15:0] cand_tdata,
  output logic        div_dividend_tvalid,
  output logic [15:0] div_dividend_tdata,
  output logic        div_divisor_tvalid,
  output logic [7:0]  div_divisor_tdata,
  input  logic        div_dout_tvalid,
  input  logic [23:0] div_dout_tdata,
  output logic        res_tvalid,
  input  logic        res_tready,
  output logic        res_prime,
  output logic [7:0]  res_factor,
  output logic [15:0] res_cand,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic [15:0]      cand_q;
  logic [7:0]       d_q, last_q, rdiv_q, factor_q;
  logic [CNT_W-1:0] issued_q, returned_q;
  logic             found_q, prime_q;

  logic             accept, rsp, hit, sq_stop, no_div, done_prime;
  logic [7:0]       d_next, last_in;
  logic [15:0]      cand_m1;
  logic             unused_quot;

  // Only the remainder matters for screening.
  assign unused_quot = ^div_dout_tdata[23:8];

  assign cand_m1 = cand_tdata - 16'd1;
  assign last_in = (cand_m1 > 16'(MAX_DIV)) ? 8'(MAX_DIV) : cand_m1[7:0];
  assign d_next  = d_q + 8'd1;
  assign accept  = (state_q == IDLE) & run_q & cand_tvalid;
  assign rsp     = div_dout_tvalid & ((state_q == ISSUE) | (state_q == DRAIN));
  assign hit     = rsp & ~found_q & (div_dout_tdata[7:0] == 8'd0);

`ifdef PRIME_SQRT_BOUND_EN
  logic [15:0] sq_next;
  assign sq_next = 16'(d_next) * 16'(d_next);
  assign sq_stop = sq_next > cand_q;
  assign no_div  = (last_in < 8'd2) | (cand_tdata < 16'd4);
`else
  assign sq_stop = 1'b0;
  assign no_div  = last_in < 8'd2;
`endif

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d             = state_q;
    done_prime          = ~found_q;
    cand_tready         = 1'b0;
    busy                = 1'b1;
    div_dividend_tvalid = 1'b0;
    div_divisor_tvalid  = 1'b0;
    res_tvalid          = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy        = 1'b0;
        cand_tready = run_q;
        done_prime  = cand_tdata >= 16'd2;
        if (run_q && cand_tvalid) begin
          if ((cand_tdata < 16'd2) || no_div) state_d = DONE;
          else                                state_d = ISSUE;
        end
      end
      ISSUE: begin
        div_dividend_tvalid = 1'b1;
        div_divisor_tvalid  = 1'b1;
        // A hit seen now still lets this cycle's divisor go out; stop afterwards.
        if (hit || (d_q == last_q) || sq_stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (returned_q == issued_q) state_d = DONE;
      end
      DONE: begin
        res_tvalid = 1'b1;
        if (res_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, job datapath and result tracking.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      cand_q     <= '0;
      d_q        <= '0;
      last_q     <= '0;
      rdiv_q     <= '0;
      factor_q   <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      found_q    <= 1'b0;
      prime_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (accept) begin
        cand_q     <= cand_tdata;
        d_q        <= 8'd2;
        last_q     <= last_in;
        rdiv_q     <= 8'd2;
        factor_q   <= '0;
        issued_q   <= '0;
        returned_q <= '0;
        found_q    <= 1'b0;
      end
      if (state_q == ISSUE) begin
        d_q      <= d_next;
        issued_q <= issued_q + CNT_W'(1);
      end
      if (rsp) begin
        returned_q <= returned_q + CNT_W'(1);
        rdiv_q     <= rdiv_q + 8'd1;
        if (hit) begin
          found_q  <= 1'b1;
          factor_q <= rdiv_q;
        end
      end
      if ((state_q != DONE) && (state_d == DONE)) prime_q <= done_prime;
    end
  end

  assign div_dividend_tdata = cand_q;
  assign div_divisor_tdata  = d_q;
  assign res_prime          = prime_q;
  assign res_factor         = factor_q;
  assign res_cand           = cand_q;

endmodule

// File: tb/tb_prime_screen_ctrl.sv
// tb_prime_screen_ctrl: randomized and directed jobs against a fixed-latency
// divider model, verdicts checked against a plain trial-division reference.
module tb_prime_screen_ctrl;

  localparam int MAX_DIV = 255;
  localparam int LAT     = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cand_tvalid, cand_tready;
  logic [15:0] cand_tdata;
  logic        div_dividend_tvalid, div_divisor_tvalid;
  logic [15:0] div_dividend_tdata;
  logic [7:0]  div_divisor_tdata;
  logic        div_dout_tvalid;
  logic [23:0] div_dout_tdata;
  logic        res_tvalid, res_tready, res_prime, busy;
  logic [7:0]  res_factor;
  logic [15:0] res_cand;

  int n_tests = 0;
  int n_fail  = 0;

  prime_screen_ctrl #(.MAX_DIV(MAX_DIV), .CNT_W(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cand_tvalid(cand_tvalid), .cand_tready(cand_tready), .cand_tdata(cand_tdata),
    .div_dividend_tvalid(div_dividend_tvalid), .div_dividend_tdata(div_dividend_tdata),
    .div_divisor_tvalid(div_divisor_tvalid), .div_divisor_tdata(div_divisor_tdata),
    .div_dout_tvalid(div_dout_tvalid), .div_dout_tdata(div_dout_tdata),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_prime(res_prime),
    .res_factor(res_factor), .res_cand(res_cand), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Divider stand-in: fixed latency pipeline, flushed by the shared reset.
  logic        pv   [LAT];
  logic [15:0] pdvd [LAT];
  logic [7:0]  pdvs [LAT];

  always @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0]   <= div_dividend_tvalid & div_divisor_tvalid;
      pdvd[0] <= div_dividend_tdata;
      pdvs[0] <= div_divisor_tdata;
      for (int i = 1; i < LAT; i++) begin
        pv[i]   <= pv[i-1];
        pdvd[i] <= pdvd[i-1];
        pdvs[i] <= pdvs[i-1];
      end
    end
  end

  always_comb begin
    div_dout_tvalid = pv[LAT-1];
    div_dout_tdata  = '0;
    if (pdvs[LAT-1] != 8'd0)
      div_dout_tdata = {pdvd[LAT-1] / 16'(pdvs[LAT-1]), 8'(pdvd[LAT-1] % 16'(pdvs[LAT-1]))};
  end

  // Port monitor: counts issues/returns and flags out-of-sequence divisors.
  int unsigned iss_cnt = 0, ret_cnt = 0, seq_err = 0, iss_base = 0;
  logic [15:0] cur_cand = '0;

  always @(negedge aclk) begin
    if (div_divisor_tvalid) begin
      if (!div_dividend_tvalid || div_dividend_tdata != cur_cand ||
          div_divisor_tdata != 8'(iss_cnt - iss_base + 2))
        seq_err++;
      iss_cnt++;
    end
    if (div_dout_tvalid) ret_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain trial division over the divisor range, plus the allowed
  // issue-count window (exact when no factor, overrun up to LAT+1 after a hit).
  task automatic model(input int c, output bit p, output int f, output int lo, output int hi);
    int last, cnt;
    p = 1'b0; f = 0; lo = 0; hi = 0;
    if (c < 2) return;
    last = (c - 1 > MAX_DIV) ? MAX_DIV : c - 1;
    cnt  = 0;
    for (int d = 2; d <= last; d++) begin
`ifdef PRIME_SQRT_BOUND_EN
      if (d * d > c) break;
`endif
      cnt++;
      if (c % d == 0) begin
        f = d; lo = cnt; hi = cnt + LAT + 1;
        return;
      end
    end
    p = 1'b1; lo = cnt; hi = cnt;
  endtask

  task automatic run_job(input logic [15:0] c, input int hold);
    bit          ep;
    int          ef, elo, ehi, lat, w, ni;
    int unsigned b_i, b_r, b_s;
    bit          stable;
    logic [24:0] snap;
    model(int'(c), ep, ef, elo, ehi);
    w = 0;
    while (!cand_tready && w < 100) begin @(posedge aclk); #1; w++; end
    check("tready_wait", 32'(cand_tready), 1);
    b_i = iss_cnt; b_r = ret_cnt; b_s = seq_err;
    iss_base = iss_cnt; cur_cand = c;
    cand_tdata = c; cand_tvalid = 1'b1;
    lat = 0;
    while (lat < 2000) begin
      @(posedge aclk); #1; lat++;
      cand_tvalid = 1'b0;
      if (res_tvalid) break;
    end
    ni = int'(iss_cnt - b_i);
    check("verdict_to", 32'(res_tvalid), 1);
    check("prime", 32'(res_prime), 32'(ep));
    check("factor", 32'(res_factor), ef);
    check("cand", 32'(res_cand), 32'(c));
    check("ret_eq_iss", ret_cnt - b_r, iss_cnt - b_i);
    check("issued_rng", 32'(ni >= elo && ni <= ehi), 1);
    check("div_seq", seq_err - b_s, 0);
    if (ehi == 0) check("lat_noissue", lat, 1);
    if (ep) check("issued_n", ni, elo);
    snap = {res_prime, res_factor, res_cand};
    if (hold > 0) begin
      stable = 1'b1;
      cand_tdata = c ^ 16'h5a5a; cand_tvalid = 1'b1;
      repeat (hold) begin
        @(posedge aclk); #1;
        if ({res_prime, res_factor, res_cand} != snap || !res_tvalid || cand_tready) stable = 1'b0;
      end
      cand_tvalid = 1'b0;
      check("hold_stable", 32'(stable), 1);
    end
    res_tready = 1'b1;
    @(posedge aclk); #1;
    res_tready = 1'b0;
    check("hs_idle", 32'({res_tvalid, cand_tready}), 1);
  endtask

  int pr [10] = '{2, 3, 5, 7, 11, 13, 31, 61, 127, 251};
  int v, hsel;

  initial begin
    aresetn = 1'b0; cand_tvalid = 1'b0; cand_tdata = '0; res_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ctrl", 32'({cand_tready, busy, div_dividend_tvalid, div_divisor_tvalid, res_tvalid, res_prime}), 0);
    check("rst_res", 32'({res_factor, res_cand}), 0);
    check("rst_div", 32'({div_dividend_tdata, div_divisor_tdata}), 0);
    aresetn = 1'b1;
    check("rdy_release", 32'(cand_tready), 0);
    @(posedge aclk); #1;
    check("rdy_up", 32'(cand_tready), 1);

    run_job(16'd59477, 20);
    run_job(16'd59477 ^ 16'h5a5a, 0);
    run_job(16'd59478, 0);
    run_job(16'd251, 0);
    run_job(16'd1, 0);
    run_job(16'd2, 0);
    run_job(16'd0, 0);
    run_job(16'd3, 0);
    run_job(16'd4, 0);
    run_job(16'd253, 1);
    run_job(16'd289, 0);
    run_job(16'd257, 0);
    run_job(16'd65025, 2);

    // Reset in the middle of a long job.
    cand_tdata = 16'd65521; cand_tvalid = 1'b1;
    @(posedge aclk); #1;
    cand_tvalid = 1'b0;
    repeat (20) @(posedge aclk);
    #1;
    check("busy_mid", 32'(busy), 1);
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("mid_rst_ctrl", 32'({cand_tready, busy, div_dividend_tvalid, div_divisor_tvalid, res_tvalid, res_prime}), 0);
    check("mid_rst_res", 32'({res_factor, res_cand}), 0);
    check("mid_rst_div", 32'({div_dividend_tdata, div_divisor_tdata}), 0);
    aresetn = 1'b1;
    check("mid_rdy_release", 32'(cand_tready), 0);
    @(posedge aclk); #1;
    check("mid_rdy_up", 32'(cand_tready), 1);
    run_job(16'd65521, 0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 30));
        1: v = int'($urandom_range(0, 65535));
        2: v = pr[$urandom_range(0, 9)] * pr[$urandom_range(0, 9)];
        default: v = int'($urandom_range(60000, 65535));
      endcase
      hsel = int'($urandom_range(0, 3));
      run_job(16'(v), hsel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
